// File: rtl/id_ex_stage.sv
// Purpose : ID/EX pipeline register. Decodes opcode/funct into a 3-bit ALU op and holds the operands,
//           with EX/MEM and MEM/WB forwarding applied combinationally on the held entry.
// Latency : 1 cycle from an id_valid&&id_ready transfer to ex_valid. Backpressure: one-entry buffer,
//           id_ready = !ex_valid || ex_ready; while stalled, the entry holds and forwarding still updates.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   flush                     drops the held entry and any same-cycle capture
//   id_valid / id_ready       handshake toward decode
//   id_pc .. id_imm           instruction fields and operand data from decode/regfile
//   exm_* / mwb_*             writeback sources for forwarding
//   ex_valid / ex_ready       handshake toward execute
//   alu_a, alu_b, alu_op      ALU operands and operation
//   ex_rd, ex_wb_en           destination and write enable
//   ex_illegal                instruction is not supported by this ALU
module id_ex_stage #(
    parameter int XLEN   = 32,
    parameter bit FWD_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            id_valid,
    output logic            id_ready,
    input  logic [XLEN-1:0] id_pc,
    input  logic [6:0]      id_opcode,
    input  logic [2:0]      id_funct3,
    input  logic            id_funct7_5,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic [4:0]      id_rd,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic            exm_wen,
    input  logic [4:0]      exm_rd,
    input  logic [XLEN-1:0] exm_data,
    input  logic            mwb_wen,
    input  logic [4:0]      mwb_rd,
    input  logic [XLEN-1:0] mwb_data,
    output logic            ex_valid,
    input  logic            ex_ready,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [2:0]      alu_op,
    output logic [4:0]      ex_rd,
    output logic            ex_wb_en,
    output logic            ex_illegal
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;
    localparam logic [2:0] OP_SLL = 3'b110;
    localparam logic [2:0] OP_SRL = 3'b111;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    // ---------------- decode ----------------
    logic [2:0]      dec_op;
    logic            dec_ill;
    logic [XLEN-1:0] dec_a;
    logic [XLEN-1:0] dec_b;
    logic            dec_fwd_a;
    logic            dec_fwd_b;
    logic [2:0]      f3_op;

    // funct3 -> ALU op, shared by OP and OP-IMM; f3=011 is rejected separately.
    always_comb begin
        f3_op = OP_ADD;
        case (id_funct3)
            3'b000:  f3_op = OP_ADD;
            3'b111:  f3_op = OP_AND;
            3'b110:  f3_op = OP_OR;
            3'b100:  f3_op = OP_XOR;
            3'b010:  f3_op = OP_SLT;
            3'b001:  f3_op = OP_SLL;
            3'b101:  f3_op = OP_SRL;
            default: f3_op = OP_ADD;
        endcase
    end

    always_comb begin
        dec_op    = OP_ADD;
        dec_ill   = 1'b0;
        dec_a     = id_rs1_data;
        dec_b     = id_rs2_data;
        dec_fwd_a = 1'b0;
        dec_fwd_b = 1'b0;
        case (id_opcode)
            OPC_OP: begin
                dec_fwd_a = 1'b1;
                dec_fwd_b = 1'b1;
                if (id_funct3 == 3'b011) begin
                    dec_ill = 1'b1;
                end else if (id_funct3 == 3'b000) begin
                    dec_op = id_funct7_5 ? OP_SUB : OP_ADD;
                end else begin
                    // instr[30] is only meaningful for SUB; anything else (incl. SRA) is unsupported
                    dec_op  = f3_op;
                    dec_ill = id_funct7_5;
                end
            end
            OPC_OP_IMM: begin
                dec_fwd_a = 1'b1;
                dec_b     = id_imm;
                dec_op    = f3_op;
                // instr[30] is an immediate bit except for the shift-right encodings (SRAI)
                if (id_funct3 == 3'b011 || (id_funct3 == 3'b101 && id_funct7_5)) begin
                    dec_ill = 1'b1;
                end
            end
            OPC_LUI: begin
                dec_a = '0;
                dec_b = id_imm;
            end
            OPC_AUIPC: begin
                dec_a = id_pc;
                dec_b = id_imm;
            end
            default: dec_ill = 1'b1;
        endcase
        if (dec_ill) begin
            dec_op = OP_ADD;
        end
    end

    // ---------------- one-entry buffer ----------------
    logic            valid_q;
    logic [2:0]      op_q;
    logic [XLEN-1:0] a_q;
    logic [XLEN-1:0] b_q;
    logic            fwd_a_q;
    logic            fwd_b_q;
    logic [4:0]      rs1_q;
    logic [4:0]      rs2_q;
    logic [4:0]      rd_q;
    logic            wb_q;
    logic            ill_q;

    assign id_ready = !valid_q || ex_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            fwd_a_q <= 1'b0;
            fwd_b_q <= 1'b0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
            wb_q    <= 1'b0;
            ill_q   <= 1'b0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (id_valid && id_ready) begin
            valid_q <= 1'b1;
            op_q    <= dec_op;
            a_q     <= dec_a;
            b_q     <= dec_b;
            fwd_a_q <= dec_fwd_a;
            fwd_b_q <= dec_fwd_b;
            rs1_q   <= id_rs1;
            rs2_q   <= id_rs2;
            rd_q    <= id_rd;
            wb_q    <= !dec_ill && (id_rd != 5'd0);
            ill_q   <= dec_ill;
        end else if (ex_ready) begin
            valid_q <= 1'b0;
        end
    end

    // ---------------- forwarding on the held entry ----------------
    // Evaluated from the registered source indices so a stalled entry picks up
    // results that retire while it waits. EX/MEM is younger and takes priority.
    function automatic logic [XLEN-1:0] fwd_sel(input logic [4:0] rs, input logic [XLEN-1:0] dflt,
                                                input logic e_wen, input logic [4:0] e_rd,
                                                input logic [XLEN-1:0] e_dat, input logic m_wen,
                                                input logic [4:0] m_rd, input logic [XLEN-1:0] m_dat);
        if (e_wen && e_rd == rs && rs != 5'd0) begin
            return e_dat;
        end else if (m_wen && m_rd == rs && rs != 5'd0) begin
            return m_dat;
        end
        return dflt;
    endfunction

    always_comb begin
        alu_a = a_q;
        alu_b = b_q;
        if (FWD_EN && fwd_a_q) begin
            alu_a = fwd_sel(rs1_q, a_q, exm_wen, exm_rd, exm_data, mwb_wen, mwb_rd, mwb_data);
        end
        if (FWD_EN && fwd_b_q) begin
            alu_b = fwd_sel(rs2_q, b_q, exm_wen, exm_rd, exm_data, mwb_wen, mwb_rd, mwb_data);
        end
    end

    assign ex_valid   = valid_q;
    assign alu_op     = op_q;
    assign ex_rd      = rd_q;
    assign ex_wb_en   = wb_q;
    assign ex_illegal = ill_q;

endmodule
